wb_port_arbiter: RTL and testbench

Write-back arbiter for the two-write-port register file. It takes write-back requests from `NUM_REQ` functional units and grants at most two per cycle, round-robin. It drives the register file's `ld_a/dest_a/in_a` and `ld_b/dest_b/in_b` ports from a registered output stage. It guarantees the two ports never target the same register in one cycle, so the register file's same-destination priority path never fires.

---
 rtl/wb_port_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: grants up to two round-robin requesters per cycle onto the
// register file's two write ports, never pairing two writes to the same register.
module wb_port_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned s_width = 32,
    parameter int unsigned s_index = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_stall,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*s_index-1:0]   req_dest,
    input  logic [NUM_REQ*s_width-1:0]   req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         ld_a,
    output logic                         ld_b,
    output logic [s_index-1:0]           dest_a,
    output logic [s_index-1:0]           dest_b,
    output logic [s_width-1:0]           in_a,
    output logic [s_width-1:0]           in_b,
    output logic                         prefer_a,
    output logic                         busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   a_idx;
    logic [PTR_W-1:0]   b_idx;
    logic [PTR_W-1:0]   last_idx;
    logic [PTR_W-1:0]   rr_next;
    logic               found_a;
    logic               found_b;
    logic               grant;
    logic               nxt_ld_a;
    logic               nxt_ld_b;
    logic [s_index-1:0] sel_dest_a;
    logic [s_index-1:0] sel_dest_b;
    logic [s_width-1:0] sel_data_a;
    logic [s_width-1:0] sel_data_b;
    logic [s_index-1:0] dest_arr [NUM_REQ];
    logic [s_width-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dest_arr[g] = req_dest[g*s_index +: s_index];
        assign data_arr[g] = req_data[g*s_width +: s_width];
    end

    // Scan from the pointer with wrap: first valid is A, next valid with a different dest is B.
    always_comb begin : pick_comb
        int unsigned         idx;
        logic [PTR_W-1:0]    pi;
        found_a    = 1'b0;
        found_b    = 1'b0;
        a_idx      = '0;
        b_idx      = '0;
        sel_dest_a = '0;
        sel_dest_b = '0;
        sel_data_a = '0;
        sel_data_b = '0;
        idx        = 0;
        pi         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            pi  = PTR_W'(idx);
            if (req_valid[pi]) begin
                if (!found_a) begin
                    found_a    = 1'b1;
                    a_idx      = pi;
                    sel_dest_a = dest_arr[pi];
                    sel_data_a = data_arr[pi];
                end else if (!found_b && (dest_arr[pi] != sel_dest_a)) begin
                    found_b    = 1'b1;
                    b_idx      = pi;
                    sel_dest_b = dest_arr[pi];
                    sel_data_b = data_arr[pi];
                end
            end
        end
    end

    assign grant    = rst_n & ~wb_stall & found_a;
    assign nxt_ld_a = grant & (sel_dest_a != '0);
    assign nxt_ld_b = grant & found_b & (sel_dest_b != '0);
    assign last_idx = found_b ? b_idx : a_idx;
    assign rr_next  = (last_idx == LAST_IDX) ? '0 : last_idx + PTR_W'(1);

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[a_idx] = 1'b1;
            if (found_b) begin
                req_ready[b_idx] = 1'b1;
            end
        end
    end

    // Register-0 grants are accepted but their load enable is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            ld_a     <= 1'b0;
            ld_b     <= 1'b0;
            dest_a   <= '0;
            dest_b   <= '0;
            in_a     <= '0;
            in_b     <= '0;
            prefer_a <= 1'b1;
            busy     <= 1'b0;
        end else begin
            ld_a     <= nxt_ld_a;
            ld_b     <= nxt_ld_b;
            busy     <= nxt_ld_a | nxt_ld_b;
            prefer_a <= 1'b1;
            if (grant) begin
                dest_a <= sel_dest_a;
                dest_b <= sel_dest_b;
                in_a   <= sel_data_a;
                in_b   <= sel_data_b;
                rr_ptr <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against
// a queue-based round-robin model.
module tb_wb_port_arbiter;

    localparam int N  = 4;
    localparam int SW = 32;
    localparam int SI = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_stall = 1'b0;
    logic [N-1:0]  t_valid = '0;
    logic [SI-1:0] t_dest [N];
    logic [SW-1:0] t_data [N];
    logic [N*SI-1:0] req_dest;
    logic [N*SW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          ld_a, ld_b, prefer_a, busy;
    logic [SI-1:0] dest_a, dest_b;
    logic [SW-1:0] in_a, in_b;

    int total = 0;
    int bad   = 0;

    // Model state: pointer and expected registered outputs.
    int            m_ptr = 0;
    logic          e_ld_a = 1'b0, e_ld_b = 1'b0, e_busy = 1'b0;
    logic [SI-1:0] e_dest_a = '0, e_dest_b = '0;
    logic [SW-1:0] e_in_a = '0, e_in_b = '0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_dest[g*SI +: SI] = t_dest[g];
        assign req_data[g*SW +: SW] = t_data[g];
    end

    wb_port_arbiter #(.NUM_REQ(N), .s_width(SW), .s_index(SI)) dut (
        .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
        .req_valid(t_valid), .req_dest(req_dest), .req_data(req_data),
        .req_ready(req_ready),
        .ld_a(ld_a), .ld_b(ld_b), .dest_a(dest_a), .dest_b(dest_b),
        .in_a(in_a), .in_b(in_b), .prefer_a(prefer_a), .busy(busy)
    );

    always #5 clk = ~clk;

    // List valid units in rotation order, then pick A and the first later one with a different dest.
    function automatic void pick(output int a, output int b);
        int order[$];
        a = -1;
        b = -1;
        for (int k = 0; k < N; k++) begin
            if (t_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
        end
        if (order.size() > 0) begin
            a = order[0];
            for (int j = 1; j < order.size(); j++) begin
                if (b < 0 && t_dest[order[j]] != t_dest[a]) b = order[j];
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int a, b;
        logic [N-1:0] r;
        r = '0;
        pick(a, b);
        if (rst_n && !wb_stall && a >= 0) begin
            r[a] = 1'b1;
            if (b >= 0) r[b] = 1'b1;
        end
        return r;
    endfunction

    // One clock: model reacts to the inputs present before the edge; returns at edge+1.
    task automatic advance();
        int a, b;
        logic g;
        pick(a, b);
        g = rst_n && !wb_stall && (a >= 0);
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; e_ld_a = 1'b0; e_ld_b = 1'b0; e_busy = 1'b0;
        end else begin
            e_ld_a = 1'b0;
            e_ld_b = 1'b0;
            if (g) begin
                e_ld_a   = (t_dest[a] != 0);
                e_dest_a = t_dest[a];
                e_in_a   = t_data[a];
                if (b >= 0) begin
                    e_ld_b   = (t_dest[b] != 0);
                    e_dest_b = t_dest[b];
                    e_in_b   = t_data[b];
                end
                m_ptr = (((b >= 0) ? b : a) + 1) % N;
            end
            e_busy = e_ld_a | e_ld_b;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        t_valid  = '0;
        wb_stall = 1'b0;
        advance();
        rst_n = 1'b1;
    endtask

    task automatic set_all_distinct();
        for (int i = 0; i < N; i++) begin
            t_dest[i] = SI'(i + 1);
            t_data[i] = $urandom;
        end
        t_valid = '1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_all_distinct();
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
            advance();
        end
        total++;
        if ({ld_a, ld_b, busy, prefer_a} !== 4'b0001) begin
            bad++; $display("FAIL reset_outputs: ld_a/ld_b/busy/prefer_a got %b want 0001", {ld_a, ld_b, busy, prefer_a});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0011) begin bad++; $display("FAIL reset_first_grant: got %b want 0011", req_ready); end
        advance();
    endtask

    task automatic test_full_load();
        logic [N-1:0]  want_r  [3] = '{4'b0011, 4'b1100, 4'b0011};
        logic [SI-1:0] want_da [3] = '{5'd1, 5'd3, 5'd1};
        logic [SI-1:0] want_db [3] = '{5'd2, 5'd4, 5'd2};
        do_reset();
        set_all_distinct();
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req_ready !== want_r[c]) begin bad++; $display("FAIL full_ready[%0d]: got %b want %b", c, req_ready, want_r[c]); end
            advance();
            total++;
            if ({ld_a, ld_b, dest_a, dest_b} !== {2'b11, want_da[c], want_db[c]}) begin
                bad++; $display("FAIL full_ports[%0d]: ld=%b%b dest=%0d/%0d want ld=11 dest=%0d/%0d",
                                c, ld_a, ld_b, dest_a, dest_b, want_da[c], want_db[c]);
            end
            total++;
            if (in_a !== t_data[(c % 2) * 2] || in_b !== t_data[(c % 2) * 2 + 1]) begin
                bad++; $display("FAIL full_data[%0d]: got %h/%h want %h/%h", c, in_a, in_b,
                                t_data[(c % 2) * 2], t_data[(c % 2) * 2 + 1]);
            end
        end
    endtask

    task automatic test_conflict();
        do_reset();
        t_dest[0] = 5'd7; t_dest[1] = 5'd7; t_dest[2] = 5'd9; t_dest[3] = 5'd1;
        t_valid = 4'b0111;
        #1;
        total++;
        if (req_ready !== 4'b0101) begin bad++; $display("FAIL conflict_ready0: got %b want 0101", req_ready); end
        advance();
        total++;
        if ({ld_a, ld_b, dest_a, dest_b} !== {2'b11, 5'd7, 5'd9}) begin
            bad++; $display("FAIL conflict_ports0: ld=%b%b dest=%0d/%0d want ld=11 dest=7/9", ld_a, ld_b, dest_a, dest_b);
        end
        t_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL conflict_ready1: got %b want 0010", req_ready); end
        advance();
        total++;
        if ({ld_a, ld_b, dest_a} !== {2'b10, 5'd7}) begin
            bad++; $display("FAIL conflict_ports1: ld=%b%b dest_a=%0d want ld=10 dest_a=7", ld_a, ld_b, dest_a);
        end
    endtask

    task automatic test_reg0();
        do_reset();
        t_dest[3] = 5'd0;
        t_data[3] = 32'hDEAD_BEEF;
        t_valid = 4'b1000;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin bad++; $display("FAIL reg0_ready: got %b want 1000", req_ready); end
        advance();
        total++;
        if ({ld_a, ld_b, busy} !== 3'b000) begin bad++; $display("FAIL reg0_discard: ld_a/ld_b/busy got %b want 000", {ld_a, ld_b, busy}); end
        set_all_distinct();
        #1;
        total++;
        if (req_ready !== 4'b0011) begin bad++; $display("FAIL reg0_ptr_wrap: got %b want 0011", req_ready); end
        advance();
    endtask

    task automatic test_stall();
        do_reset();
        set_all_distinct();
        #1;
        advance();
        wb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, req_ready); end
            advance();
            total++;
            if ({ld_a, ld_b} !== 2'b00) begin bad++; $display("FAIL stall_ld[%0d]: got %b want 00", c, {ld_a, ld_b}); end
        end
        wb_stall = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b1100) begin bad++; $display("FAIL stall_release: got %b want 1100", req_ready); end
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_all_distinct();
        #1;
        advance();
        #1;
        total++;
        if (req_ready !== 4'b1100) begin bad++; $display("FAIL mid_grant_T: got %b want 1100", req_ready); end
        advance();
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready_rst: got %b want 0000", req_ready); end
        total++;
        if ({ld_a, ld_b, dest_a, dest_b} !== {2'b11, 5'd3, 5'd4}) begin
            bad++; $display("FAIL mid_writes_complete: ld=%b%b dest=%0d/%0d want ld=11 dest=3/4", ld_a, ld_b, dest_a, dest_b);
        end
        advance();
        total++;
        if ({ld_a, ld_b, busy} !== 3'b000) begin bad++; $display("FAIL mid_after_rst: ld_a/ld_b/busy got %b want 000", {ld_a, ld_b, busy}); end
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0011) begin bad++; $display("FAIL mid_ptr_zero: got %b want 0011", req_ready); end
        advance();
    endtask

    task automatic test_random();
        logic [N-1:0] r_exp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!t_valid[i] && $urandom_range(0, 2) != 0) begin
                    t_valid[i] = 1'b1;
                    t_dest[i]  = SI'($urandom_range(0, 5));
                    t_data[i]  = $urandom;
                end
            end
            wb_stall = ($urandom_range(0, 4) == 0);
            #1;
            r_exp = exp_ready();
            total++;
            if (req_ready !== r_exp) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, r_exp); end
            advance();
            total++;
            if ({ld_a, ld_b, busy, prefer_a} !== {e_ld_a, e_ld_b, e_busy, 1'b1}) begin
                bad++; $display("FAIL rnd_ctrl[%0d]: ld_a/ld_b/busy/prefer_a got %b want %b", c,
                                {ld_a, ld_b, busy, prefer_a}, {e_ld_a, e_ld_b, e_busy, 1'b1});
            end
            if (e_ld_a) begin
                total++;
                if (dest_a !== e_dest_a || in_a !== e_in_a) begin
                    bad++; $display("FAIL rnd_port_a[%0d]: got %0d/%h want %0d/%h", c, dest_a, in_a, e_dest_a, e_in_a);
                end
            end
            if (e_ld_b) begin
                total++;
                if (dest_b !== e_dest_b || in_b !== e_in_b) begin
                    bad++; $display("FAIL rnd_port_b[%0d]: got %0d/%h want %0d/%h", c, dest_b, in_b, e_dest_b, e_in_b);
                end
            end
            if (e_ld_a && e_ld_b) begin
                total++;
                if (dest_a === dest_b) begin bad++; $display("FAIL rnd_same_dest[%0d]: both ports got %0d want distinct", c, dest_a); end
            end
            t_valid = t_valid & ~r_exp;
        end
        wb_stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            t_dest[i] = '0;
            t_data[i] = '0;
        end
        test_reset();
        test_full_load();
        test_conflict();
        test_reg0();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
